// File: rtl/maxpool_stage.sv
// maxpool_stage: 2x2 / stride-2 max-pooling of an N-channel raster pixel stream into a write memory.
// Define MAXPOOL_RELU_EN for signed comparison with a fused ReLU clamp on the pooled result.
module maxpool_stage #(
    parameter int  N    = 4,
    parameter int  W    = 10,
    parameter int  H    = 10,
    parameter int  DW   = 8,
    localparam int NOUT = (W / 2) * (H / 2),
    localparam int AW   = (NOUT > 1) ? $clog2(NOUT) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data,
    output logic [AW-1:0]   out_addr,
    output logic            done
);

    localparam int OW = (W / 2 > 0) ? W / 2 : 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int LW = (OW > 1) ? $clog2(OW) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            done_nxt;

    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [N*DW-1:0] pair;
    logic [N*DW-1:0] line_buf [OW];

    logic            beat;
    logic            out_hs;
    logic            col_last;
    logic            row_last;
    logic            res_load;
    logic [LW-1:0]   lb_idx;
    logic [N*DW-1:0] lb_new;
    logic [N*DW-1:0] pooled;
    logic [AW-1:0]   addr_calc;

    function automatic logic [DW-1:0] pix_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL_RELU_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    function automatic logic [DW-1:0] pix_clamp(input logic [DW-1:0] a);
`ifdef MAXPOOL_RELU_EN
        return a[DW-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    // A stalled output slot blocks intake, so a new result can never overwrite an unread one.
    assign in_ready = (state == S_RUN) && !(out_valid && !out_ready);
    assign beat     = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign col_last = (col == CW'(W - 1));
    assign row_last = (row == RW'(H - 1));

    // Odd rows/cols are never the dropped trailing row/col of an odd-sized map, so floor semantics fall out.
    assign res_load  = beat && row[0] && col[0];
    assign lb_idx    = LW'(col >> 1);
    assign addr_calc = AW'(int'(row >> 1) * OW + int'(col >> 1));

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        lb_new = '0;
        pooled = '0;
        for (int c = 0; c < N; c++) begin
            lb_new[c*DW +: DW] = pix_max(pair[c*DW +: DW], in_data[c*DW +: DW]);
            pooled[c*DW +: DW] = pix_clamp(pix_max(lb_new[c*DW +: DW], line_buf[lb_idx][c*DW +: DW]));
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (beat && col_last && row_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            pair      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                col      <= '0;
                row      <= '0;
                out_addr <= '0;
            end else if (beat) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) pair <= in_data;
            end

            if (res_load) begin
                out_data  <= pooled;
                out_addr  <= addr_calc;
                out_valid <= 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the line buffer is small, so it is cleared on reset like the other state rather than left undefined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OW; i++) line_buf[i] <= '0;
        end else if (beat && !row[0] && col[0]) begin
            line_buf[lb_idx] <= lb_new;
        end
    end

endmodule

// File: tb/tb_maxpool_stage.sv
// tb_maxpool_stage: drives three maxpool_stage sizes (10x10, 4x4, 5x5) and checks them against a
// frame-level max-pool model; honours MAXPOOL_RELU_EN the same way the design does.
module tb_maxpool_stage;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NB = N * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [NB-1:0] in_data = '0;
    logic [1:0]    sel = 2'd0;

    logic          rdy_a, ov_a, dn_a;
    logic          rdy_b, ov_b, dn_b;
    logic          rdy_c, ov_c, dn_c;
    logic [NB-1:0] od_a, od_b, od_c;
    logic [4:0]    ad_a;
    logic [1:0]    ad_b, ad_c;

    logic          cur_rdy, cur_ov, cur_dn;
    logic [NB-1:0] cur_od;
    logic [31:0]   cur_addr;

    int checks = 0;
    int errors = 0;

    logic [NB-1:0] pix [100];
    logic [NB-1:0] exp_d [$];
    int            exp_a [$];

    always #5 clk = ~clk;

    maxpool_stage #(.N(N), .W(10), .H(10), .DW(DW)) u_dut_a (
        .clk(clk), .rst(rst), .start(start && sel == 2'd0),
        .in_valid(in_valid && sel == 2'd0), .in_ready(rdy_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_addr(ad_a), .done(dn_a)
    );

    maxpool_stage #(.N(N), .W(4), .H(4), .DW(DW)) u_dut_b (
        .clk(clk), .rst(rst), .start(start && sel == 2'd1),
        .in_valid(in_valid && sel == 2'd1), .in_ready(rdy_b), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_addr(ad_b), .done(dn_b)
    );

    maxpool_stage #(.N(N), .W(5), .H(5), .DW(DW)) u_dut_c (
        .clk(clk), .rst(rst), .start(start && sel == 2'd2),
        .in_valid(in_valid && sel == 2'd2), .in_ready(rdy_c), .in_data(in_data),
        .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_addr(ad_c), .done(dn_c)
    );

    always_comb begin
        cur_rdy  = 1'b0;
        cur_ov   = 1'b0;
        cur_dn   = 1'b0;
        cur_od   = '0;
        cur_addr = '0;
        case (sel)
            2'd0: begin cur_rdy = rdy_a; cur_ov = ov_a; cur_dn = dn_a; cur_od = od_a; cur_addr = 32'(ad_a); end
            2'd1: begin cur_rdy = rdy_b; cur_ov = ov_b; cur_dn = dn_b; cur_od = od_b; cur_addr = 32'(ad_b); end
            2'd2: begin cur_rdy = rdy_c; cur_ov = ov_c; cur_dn = dn_c; cur_od = od_c; cur_addr = 32'(ad_c); end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame contents: 0 ramp, 1 (idx*3 + c*17) mod 256, 2 random, 3 random with an all-negative top-left block.
    task automatic fill(input int mode, input int w, input int h);
        for (int i = 0; i < w * h; i++) begin
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0:       pix[i][c*DW +: DW] = 8'(i + 40 * c);
                    1:       pix[i][c*DW +: DW] = 8'(i * 3 + c * 17);
                    default: pix[i][c*DW +: DW] = 8'($urandom);
                endcase
            end
        end
        if (mode == 3) begin
            pix[0]     = {N{8'hF0}};
            pix[1]     = {N{8'h80}};
            pix[w]     = {N{8'hFF}};
            pix[w + 1] = {N{8'h90}};
        end
    endtask

    // Software max-pool: every complete 2x2 block, raster order over blocks.
    task automatic build_model(input int w, input int h);
        logic [NB-1:0] r;
        logic [DW-1:0] b;
        int            best;
        int            val;
        exp_d.delete();
        exp_a.delete();
        for (int pr = 0; pr < h / 2; pr++) begin
            for (int pc = 0; pc < w / 2; pc++) begin
                r = '0;
                for (int c = 0; c < N; c++) begin
                    best = -100000;
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            b = pix[(2 * pr + dr) * w + 2 * pc + dc][c*DW +: DW];
`ifdef MAXPOOL_RELU_EN
                            val = int'($signed(b));
`else
                            val = int'(b);
`endif
                            if (val > best) best = val;
                        end
                    end
`ifdef MAXPOOL_RELU_EN
                    if (best < 0) best = 0;
`endif
                    r[c*DW +: DW] = 8'(best);
                end
                exp_d.push_back(r);
                exp_a.push_back(pr * (w / 2) + pc);
            end
        end
    endtask

    task automatic run_frame(input int s, input int w, input int h, input int stall_pct,
                             input int gap_pct, input bit stall_first, input string tag);
        int            idx;
        int            cyc;
        int            last_hs;
        int            done_n;
        int            done_cyc;
        int            stall_cnt;
        bit            hold;
        logic [NB-1:0] hd;
        logic [31:0]   ha;
        logic [NB-1:0] ed;
        int            ea;
        build_model(w, h);
        sel = 2'(s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; last_hs = -1; done_n = 0; done_cyc = -1; stall_cnt = 0; hold = 1'b0;
        hd = '0; ha = '0;
        while (cyc < 3000 && done_n == 0) begin
            out_ready = stall_first ? (stall_cnt >= 5) : ($urandom_range(99) >= 32'(stall_pct));
            in_valid  = (idx < w * h) && ($urandom_range(99) >= 32'(gap_pct));
            in_data   = (idx < w * h) ? pix[idx] : NB'($urandom);
            start     = (idx < w * h) && ($urandom_range(99) < 5);
            #1;
            if (hold) begin
                check({tag, "_hold_valid"}, 32'(cur_ov), 32'd1);
                check({tag, "_hold_data"}, cur_od, hd);
                check({tag, "_hold_addr"}, cur_addr, ha);
            end
            if (cur_ov && out_ready) begin
                check({tag, "_extra_out"}, 32'(exp_d.size() > 0), 32'd1);
                if (exp_d.size() > 0) begin
                    ed = exp_d.pop_front();
                    ea = exp_a.pop_front();
                    check({tag, "_data"}, cur_od, ed);
                    check({tag, "_addr"}, cur_addr, 32'(ea));
                end
                last_hs = cyc;
            end
            if (cur_ov && !out_ready) begin
                check({tag, "_stall_ready"}, 32'(cur_rdy), 32'd0);
                stall_cnt++;
            end
            hold = cur_ov && !out_ready;
            hd   = cur_od;
            ha   = cur_addr;
            if (in_valid && cur_rdy) idx++;
            if (cur_dn) begin
                done_n++;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        check({tag, "_done_seen"}, 32'(done_n), 32'd1);
        check({tag, "_beats"}, 32'(idx), 32'(w * h));
        check({tag, "_left"}, 32'(exp_d.size()), 32'd0);
        check({tag, "_done_after_out"}, 32'(done_cyc > last_hs), 32'd1);
        if (done_n == 1 && w % 2 == 0 && h % 2 == 0 && stall_pct == 0)
            check({tag, "_done_lat"}, 32'(done_cyc - last_hs), 32'd1);
        in_valid = 1'b1;
        #1;
        check({tag, "_idle_ready"}, 32'(cur_rdy), 32'd0);
        check({tag, "_done_pulse"}, 32'(cur_dn), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(cur_ov), 32'd0);
        check("rst_data", cur_od, 32'd0);
        check("rst_addr", cur_addr, 32'd0);
        check("rst_done", 32'(cur_dn), 32'd0);
        check("rst_ready", 32'(cur_rdy), 32'd0);
        check("rst_valid_b", 32'(ov_b), 32'd0);
        check("rst_valid_c", 32'(ov_c), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        fill(0, 4, 4);
        run_frame(1, 4, 4, 0, 0, 1'b0, "basic");
        run_frame(1, 4, 4, 0, 0, 1'b1, "bp");

        fill(1, 10, 10);
        run_frame(0, 10, 10, 0, 0, 1'b0, "mchan");
        run_frame(0, 10, 10, 30, 30, 1'b0, "mchan_rand");

        fill(0, 5, 5);
        run_frame(2, 5, 5, 0, 0, 1'b0, "odd");

        fill(0, 4, 4);
        sel = 2'd1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = pix[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(cur_ov), 32'd0);
        check("midrst_data", cur_od, 32'd0);
        check("midrst_addr", cur_addr, 32'd0);
        check("midrst_done", 32'(cur_dn), 32'd0);
        check("midrst_ready", 32'(cur_rdy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("postrst_done", 32'(cur_dn), 32'd0);
            check("postrst_ready", 32'(cur_rdy), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        run_frame(1, 4, 4, 0, 0, 1'b0, "rst_rerun");

        fill(3, 4, 4);
        run_frame(1, 4, 4, 0, 0, 1'b0, "relu");

        for (int k = 0; k < 3; k++) begin
            fill(2, 10, 10);
            run_frame(0, 10, 10, 30, 30, 1'b0, "rand_a");
        end
        for (int k = 0; k < 2; k++) begin
            fill(2, 5, 5);
            run_frame(2, 5, 5, 40, 20, 1'b0, "rand_c");
            fill(2, 4, 4);
            run_frame(1, 4, 4, 25, 25, 1'b0, "rand_b");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
